// File: rtl/axis_batch_cmd_parser.sv
// AXI-Stream command front end for the BRAM batch FSM: header decode, instruction/done handshake, status beat.
// Optional macro PARSER_WATCHDOG_EN adds an EXEC timeout that reports status code 3.
module axis_batch_cmd_parser #(
  parameter logic [7:0]  HEADER_MAGIC   = 8'hC0,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [31:0] payload_tdata,
  output logic        payload_tvalid,
  input  logic        payload_tready,
  output logic        payload_tlast,
  output logic [7:0]  Instruction_code,
  output logic [4:0]  wr_bram_start,
  output logic [4:0]  wr_bram_end,
  output logic [2:0]  rd_bram_start,
  output logic [2:0]  rd_bram_end,
  output logic [15:0] wr_addr_start,
  output logic [15:0] wr_addr_count,
  output logic [15:0] rd_addr_start,
  output logic [15:0] rd_addr_count,
  input  logic        batch_write_done,
  input  logic        batch_read_done,
  output logic [31:0] m_status_tdata,
  output logic        m_status_tvalid,
  input  logic        m_status_tready,
  output logic        m_status_tlast,
  output logic        busy
);
  typedef enum logic [2:0] {HDR0, HDR1, HDR2, EXEC, DRAIN, STATUS} state_t;

  state_t      state;
  logic        hdr_ready;
  logic [7:0]  op_field;
  logic [15:0] w0_low;
  logic [31:0] w1;
  logic [3:0]  code;
  logic [15:0] count;
  logic [15:0] count_next;
  logic        pass;
  logic        hs;
  logic        pay_hs;
  logic        done;
  logic        magic_ok;
  logic        op_ok;

  if (TIMEOUT_CYCLES == 0) begin : g_timeout_guard
  end

  // Header stages accept via a registered ready; EXEC write/duplex is a pure passthrough.
  assign pass           = (state == EXEC) && (op_field == 8'h01 || op_field == 8'h03);
  assign s_axis_tready  = hdr_ready | (pass & payload_tready);
  assign payload_tvalid = pass & s_axis_tvalid;
  assign payload_tdata  = pass ? s_axis_tdata : 32'h0;
  assign payload_tlast  = pass & s_axis_tlast;
  assign m_status_tlast = m_status_tvalid;
  assign busy           = (state != HDR0);

  assign hs         = s_axis_tvalid & s_axis_tready;
  assign pay_hs     = payload_tvalid & payload_tready;
  assign count_next = (pay_hs && count != 16'hFFFF) ? count + 16'd1 : count;
  assign magic_ok   = (s_axis_tdata[31:24] == HEADER_MAGIC);
  assign op_ok      = (s_axis_tdata[23:16] == 8'h01) || (s_axis_tdata[23:16] == 8'h02) ||
                      (s_axis_tdata[23:16] == 8'h03);

  always_comb begin
    done = 1'b0;
    case (op_field)
      8'h01:   done = batch_write_done;
      8'h02:   done = batch_read_done;
      8'h03:   done = batch_write_done & batch_read_done;
      default: done = 1'b0;
    endcase
  end

`ifdef PARSER_WATCHDOG_EN
  logic [31:0] wd_cnt;
  logic        tlast_seen;
  logic        tlast_now;
  logic        wd_fire;
  assign tlast_now = tlast_seen | (pay_hs & s_axis_tlast);
  assign wd_fire   = (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
`endif

  function automatic logic [31:0] status_word(input logic [3:0] c, input logic [7:0] op,
                                              input logic [15:0] cnt);
    return {4'hA, c, op, cnt};
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state            <= HDR0;
      hdr_ready        <= 1'b0;
      op_field         <= 8'h00;
      w0_low           <= 16'h0;
      w1               <= 32'h0;
      code             <= 4'h0;
      count            <= 16'h0;
      Instruction_code <= 8'h00;
      wr_bram_start    <= 5'd0;
      wr_bram_end      <= 5'd0;
      rd_bram_start    <= 3'd0;
      rd_bram_end      <= 3'd0;
      wr_addr_start    <= 16'h0;
      wr_addr_count    <= 16'h0;
      rd_addr_start    <= 16'h0;
      rd_addr_count    <= 16'h0;
      m_status_tdata   <= 32'h0;
      m_status_tvalid  <= 1'b0;
`ifdef PARSER_WATCHDOG_EN
      wd_cnt           <= 32'h0;
      tlast_seen       <= 1'b0;
`endif
    end else begin
      count <= count_next;
      case (state)
        HDR0: begin
          hdr_ready <= 1'b1;
          if (hs) begin
            op_field <= s_axis_tdata[23:16];
            w0_low   <= s_axis_tdata[15:0];
            if (!magic_ok || !op_ok) begin
              code <= magic_ok ? 4'd2 : 4'd1;
              if (s_axis_tlast) begin
                state           <= STATUS;
                hdr_ready       <= 1'b0;
                m_status_tvalid <= 1'b1;
                m_status_tdata  <= status_word(magic_ok ? 4'd2 : 4'd1, s_axis_tdata[23:16], count);
              end else begin
                state <= DRAIN;
              end
            end else if (s_axis_tlast) begin
              code            <= 4'd4;
              state           <= STATUS;
              hdr_ready       <= 1'b0;
              m_status_tvalid <= 1'b1;
              m_status_tdata  <= status_word(4'd4, s_axis_tdata[23:16], count);
            end else begin
              state <= HDR1;
            end
          end
        end
        HDR1: begin
          if (hs) begin
            w1 <= s_axis_tdata;
            if (s_axis_tlast) begin
              code            <= 4'd4;
              state           <= STATUS;
              hdr_ready       <= 1'b0;
              m_status_tvalid <= 1'b1;
              m_status_tdata  <= status_word(4'd4, op_field, count);
            end else begin
              state <= HDR2;
            end
          end
        end
        HDR2: begin
          if (hs) begin
            wr_bram_start    <= w0_low[15:11];
            wr_bram_end      <= w0_low[10:6];
            rd_bram_start    <= w0_low[5:3];
            rd_bram_end      <= w0_low[2:0];
            wr_addr_start    <= w1[31:16];
            wr_addr_count    <= w1[15:0];
            rd_addr_start    <= s_axis_tdata[31:16];
            rd_addr_count    <= s_axis_tdata[15:0];
            Instruction_code <= op_field;
            code             <= 4'd0;
            hdr_ready        <= 1'b0;
            state            <= EXEC;
`ifdef PARSER_WATCHDOG_EN
            wd_cnt           <= 32'h0;
            tlast_seen       <= 1'b0;
`endif
          end
        end
        EXEC: begin
          // Dropping the code on the done edge keeps the batch FSM from relaunching in its IDLE.
          if (done) begin
            Instruction_code <= 8'h00;
            state            <= STATUS;
            m_status_tvalid  <= 1'b1;
            m_status_tdata   <= status_word(code, op_field, count_next);
          end
`ifdef PARSER_WATCHDOG_EN
          else if (wd_fire) begin
            Instruction_code <= 8'h00;
            code             <= 4'd3;
            if (pass && !tlast_now) begin
              state     <= DRAIN;
              hdr_ready <= 1'b1;
            end else begin
              state           <= STATUS;
              m_status_tvalid <= 1'b1;
              m_status_tdata  <= status_word(4'd3, op_field, count_next);
            end
          end else begin
            wd_cnt     <= wd_cnt + 32'd1;
            tlast_seen <= tlast_now;
          end
`endif
        end
        DRAIN: begin
          if (hs && s_axis_tlast) begin
            state           <= STATUS;
            hdr_ready       <= 1'b0;
            m_status_tvalid <= 1'b1;
            m_status_tdata  <= status_word(code, op_field, count);
          end
        end
        STATUS: begin
          if (m_status_tready) begin
            m_status_tvalid <= 1'b0;
            m_status_tdata  <= 32'h0;
            count           <= 16'h0;
            hdr_ready       <= 1'b1;
            state           <= HDR0;
          end
        end
        default: state <= HDR0;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_batch_cmd_parser.sv
// Scoreboard bench for axis_batch_cmd_parser: directed command sequences followed by a randomized command mix.
module tb_axis_batch_cmd_parser;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_axis_tdata = 32'h0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [31:0] payload_tdata;
  logic        payload_tvalid;
  logic        payload_tready = 1'b1;
  logic        payload_tlast;
  logic [7:0]  Instruction_code;
  logic [4:0]  wr_bram_start, wr_bram_end;
  logic [2:0]  rd_bram_start, rd_bram_end;
  logic [15:0] wr_addr_start, wr_addr_count, rd_addr_start, rd_addr_count;
  logic        batch_write_done = 1'b0;
  logic        batch_read_done = 1'b0;
  logic [31:0] m_status_tdata;
  logic        m_status_tvalid;
  logic        m_status_tready = 1'b1;
  logic        m_status_tlast;
  logic        busy;

  axis_batch_cmd_parser dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .payload_tdata(payload_tdata), .payload_tvalid(payload_tvalid),
    .payload_tready(payload_tready), .payload_tlast(payload_tlast),
    .Instruction_code(Instruction_code),
    .wr_bram_start(wr_bram_start), .wr_bram_end(wr_bram_end),
    .rd_bram_start(rd_bram_start), .rd_bram_end(rd_bram_end),
    .wr_addr_start(wr_addr_start), .wr_addr_count(wr_addr_count),
    .rd_addr_start(rd_addr_start), .rd_addr_count(rd_addr_count),
    .batch_write_done(batch_write_done), .batch_read_done(batch_read_done),
    .m_status_tdata(m_status_tdata), .m_status_tvalid(m_status_tvalid),
    .m_status_tready(m_status_tready), .m_status_tlast(m_status_tlast),
    .busy(busy)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_status_q[$];
  logic [32:0] exp_pay_q[$];
  logic [87:0] exp_instr_q[$];
  bit          rand_ready = 1'b0;
  bit          stall_status = 1'b0;
  logic [7:0]  prev_code = 8'h00;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportExtra(input string name, input logic [127:0] act);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got 0x%0h, expected nothing pending in the scoreboard", name, act);
  endtask

  task automatic give_up(input string what);
    checks++;
    failures++;
    $display("[TB] FAIL timeout_%s: no DUT response within the cycle bound, expected a handshake", what);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Reference model: status word derived directly from the header rules and the beat count.
  function automatic logic [31:0] model_status(input logic [31:0] w0, input int short_at, input int beats);
    logic [7:0] op;
    logic [3:0] c;
    int         n;
    op = w0[23:16];
    if (w0[31:24] != 8'hC0) c = 4'd1;
    else if (op < 8'd1 || op > 8'd3) c = 4'd2;
    else if (short_at != 0) c = 4'd4;
    else c = 4'd0;
    n = (c == 4'd0 && op != 8'h02) ? ((beats > 65535) ? 65535 : beats) : 0;
    return {4'hA, c, op, n[15:0]};
  endfunction

  always @(posedge aclk) begin
    #1;
    payload_tready  = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    m_status_tready = stall_status ? 1'b0 : (rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
  end

  // Monitor: pops expected payload, status and instruction records as the DUT presents them.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (payload_tvalid && payload_tready) begin
        if (exp_pay_q.size() == 0) reportExtra("payload_extra", {payload_tlast, payload_tdata});
        else checkOutput("payload_beat", {payload_tlast, payload_tdata}, exp_pay_q.pop_front());
      end
      if (m_status_tvalid && m_status_tready) begin
        checkOutput("status_tlast", m_status_tlast, 1'b1);
        if (exp_status_q.size() == 0) reportExtra("status_extra", m_status_tdata);
        else checkOutput("status_word", m_status_tdata, exp_status_q.pop_front());
      end
      if (Instruction_code != 8'h00 && prev_code == 8'h00) begin
        if (exp_instr_q.size() == 0) reportExtra("instr_extra", Instruction_code);
        else checkOutput("instr_params",
                         {Instruction_code, wr_bram_start, wr_bram_end, rd_bram_start, rd_bram_end,
                          wr_addr_start, wr_addr_count, rd_addr_start, rd_addr_count},
                         exp_instr_q.pop_front());
      end
    end
    prev_code = Instruction_code;
  end

  task automatic send_beat(input logic [31:0] d, input logic last);
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (s_axis_tready) begin
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        return;
      end
      @(posedge aclk); #1;
    end
    give_up("send_beat");
  endtask

  task automatic pulse_done(input logic wr, input logic rd);
    batch_write_done = wr;
    batch_read_done  = rd;
    @(posedge aclk); #1;
    batch_write_done = 1'b0;
    batch_read_done  = 1'b0;
  endtask

  task automatic wait_status_done();
    for (int i = 0; i < 300; i++) begin
      @(posedge aclk); #1;
      if (exp_status_q.size() == 0) return;
    end
    give_up("status");
  endtask

  task automatic applyStimulus(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                               input int nb, input int short_at, input int extra, input bit stall);
    logic [7:0]  op;
    logic [31:0] d;
    bit          bad;
    op  = w0[23:16];
    bad = (w0[31:24] != 8'hC0) || (op < 8'd1) || (op > 8'd3);
    stall_status = stall;
    exp_status_q.push_back(model_status(w0, bad ? 0 : short_at, nb));
    if (bad) begin
      send_beat(w0, extra == 0);
      for (int i = 0; i < extra; i++) send_beat($urandom, i == extra - 1);
      checkOutput("bad_hdr_no_instr", Instruction_code, 8'h00);
    end else if (short_at != 0) begin
      send_beat(w0, short_at == 1);
      if (short_at == 2) send_beat(w1, 1'b1);
      checkOutput("short_hdr_no_instr", Instruction_code, 8'h00);
    end else begin
      exp_instr_q.push_back({op, w0[15:11], w0[10:6], w0[5:3], w0[2:0], w1, w2});
      send_beat(w0, 1'b0);
      send_beat(w1, 1'b0);
      send_beat(w2, op == 8'h02);
      checkOutput("instr_latency", Instruction_code, op);
      if (op == 8'h02) begin
        s_axis_tdata  = $urandom;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge aclk);
          checkOutput("read_stalls_stream", {s_axis_tready, payload_tvalid}, 2'b00);
          @(posedge aclk); #1;
        end
        s_axis_tvalid = 1'b0;
        pulse_done(1'b1, 1'b0);
        checkOutput("read_ignores_wr_done", Instruction_code, 8'h02);
        pulse_done(1'b0, 1'b1);
      end else begin
        for (int i = 0; i < nb; i++) begin
          d = $urandom;
          exp_pay_q.push_back({i == nb - 1, d});
          send_beat(d, i == nb - 1);
        end
        if (op == 8'h01) begin
          pulse_done(1'b0, 1'b1);
          checkOutput("write_ignores_rd_done", Instruction_code, 8'h01);
          pulse_done(1'b1, 1'b0);
        end else begin
          pulse_done(1'b1, 1'b0);
          checkOutput("duplex_needs_both_wr", Instruction_code, 8'h03);
          pulse_done(1'b0, 1'b1);
          checkOutput("duplex_needs_both_rd", Instruction_code, 8'h03);
          pulse_done(1'b1, 1'b1);
        end
      end
      checkOutput("instr_cleared", Instruction_code, 8'h00);
      checkOutput("status_latency", m_status_tvalid, 1'b1);
    end
    if (stall) begin
      for (int i = 0; i < 100 && !m_status_tvalid; i++) begin
        @(posedge aclk); #1;
      end
      for (int i = 0; i < 5; i++) begin
        @(negedge aclk);
        checkOutput("status_stall_hold", {m_status_tvalid, m_status_tdata, s_axis_tready},
                    {1'b1, exp_status_q[0], 1'b0});
        @(posedge aclk); #1;
      end
      stall_status = 1'b0;
    end
    wait_status_done();
    checkOutput("idle_after_status", busy, 1'b0);
  endtask

  task automatic reset_mid_exec();
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] d;
    w0 = 32'hC001_0840;
    w1 = 32'h0100_0010;
    exp_instr_q.push_back({8'h01, w0[15:11], w0[10:6], w0[5:3], w0[2:0], w1, 32'h0});
    send_beat(w0, 1'b0);
    send_beat(w1, 1'b0);
    send_beat(32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      exp_pay_q.push_back({1'b0, d});
      send_beat(d, 1'b0);
    end
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("reset_stream_zero",
                {s_axis_tready, payload_tdata, payload_tvalid, payload_tlast,
                 m_status_tdata, m_status_tvalid, m_status_tlast, busy}, '0);
    checkOutput("reset_instr_zero",
                {Instruction_code, wr_bram_start, wr_bram_end, rd_bram_start, rd_bram_end,
                 wr_addr_start, wr_addr_count, rd_addr_start, rd_addr_count}, '0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    logic [31:0] w0;
    int          kind;
    int          short_at;
    int          extra;
    #2;
    checkOutput("por_stream_zero",
                {s_axis_tready, payload_tdata, payload_tvalid, payload_tlast,
                 m_status_tdata, m_status_tvalid, m_status_tlast, busy}, '0);
    checkOutput("por_instr_zero",
                {Instruction_code, wr_bram_start, wr_bram_end, rd_bram_start, rd_bram_end,
                 wr_addr_start, wr_addr_count, rd_addr_start, rd_addr_count}, '0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    applyStimulus(32'hC001_0040, 32'h0000_0004, 32'h0000_0000, 8, 0, 0, 1'b0);
    applyStimulus(32'hC002_0003, 32'h0000_0000, 32'h0010_0020, 0, 0, 0, 1'b0);
    applyStimulus(32'hC003_5A5B, 32'h0004_0006, 32'h0008_0003, 5, 0, 0, 1'b0);
    applyStimulus(32'h5A01_0000, 32'h1111_2222, 32'h3333_4444, 0, 0, 3, 1'b1);
    reset_mid_exec();
    applyStimulus(32'hC001_0840, 32'h0020_0008, 32'h0000_0000, 8, 0, 0, 1'b0);

    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      kind     = $urandom_range(0, 9);
      w0       = {8'hC0, 8'($urandom_range(1, 3)), 16'($urandom)};
      short_at = 0;
      extra    = 0;
      if (kind == 7) begin
        w0[31:24] = 8'hC0 ^ 8'($urandom_range(1, 255));
        extra     = $urandom_range(0, 3);
      end else if (kind == 8) begin
        w0[23:16] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(4, 255));
        extra     = $urandom_range(0, 3);
      end else if (kind == 9) begin
        short_at = $urandom_range(1, 2);
      end
      applyStimulus(w0, $urandom, $urandom, $urandom_range(1, 12), short_at, extra,
                    $urandom_range(0, 7) == 0);
    end

    checkOutput("scoreboard_drained",
                exp_status_q.size() + exp_pay_q.size() + exp_instr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
